bcd_seg_scanner: RTL

Time-multiplexed seven-segment display driver that consumes packed BCD digits from the cascaded mod-10 counters and drives a common-anode display. It snapshots all digits once per frame to avoid tearing and scans one digit per refresh slot. A ghosting guard interval keeps anodes off between digits. Leading zeros can be suppressed, and non-decimal nibbles are shown as a dash.

---
 rtl/bcd_seg_scanner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: time-multiplexed common-anode seven-segment driver.
// Scans packed BCD digits LSD first, one digit per refresh slot, with a
// guard interval of dark anodes at the start of every slot. Digits are
// snapshotted once per frame so a display never mixes two input values.
module bcd_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PCW = $clog2(REFRESH_DIV);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PCW-1:0] PC_LAST  = PCW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PCW:0]   BLANK_V  = (PCW + 1)'(BLANK_CYC);

  logic [PCW-1:0]          pc_q, pc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_bcd_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q;
  logic                    sh_lz_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic                    snap;
  logic [4*NUM_DIGITS-1:0] cur_bcd;
  logic [NUM_DIGITS-1:0]   cur_dp;
  logic                    cur_lz;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    above_zero;
  logic [3:0]              digit;

  // Active-low {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b0111111;
    endcase
  endfunction

  // Next-state and decode; the snapshot cycle decodes the incoming values
  // so they reach seg with a single cycle of latency.
  always_comb begin
    snap    = en && (idx_q == '0) && (pc_q == '0);
    cur_bcd = snap ? bcd_in   : sh_bcd_q;
    cur_dp  = snap ? dp_in    : sh_dp_q;
    cur_lz  = snap ? blank_lz : sh_lz_q;

    above_zero = 1'b1;
    lz_blank   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      above_zero = above_zero & (cur_bcd[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      lz_blank[NUM_DIGITS-1-i] = cur_lz & above_zero & (i != NUM_DIGITS - 1);
    end

    digit = cur_bcd[{idx_q, 2'b00} +: 4];

    if (pc_q == PC_LAST) begin
      pc_d  = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      pc_d  = pc_q + 1'b1;
      idx_d = idx_q;
    end

    if ({1'b0, pc_q} < BLANK_V) begin
      an_d  = '1;
      seg_d = '1;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = lz_blank[idx_q] ? 7'b1111111 : seg_of(digit);
      dp_d  = ~cur_dp[idx_q];
    end

    fd_d = (idx_q == IDX_LAST) && (pc_q == PC_LAST);
  end

  // Scan counters, frame snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      idx_q    <= '0;
      sh_bcd_q <= '0;
      sh_dp_q  <= '0;
      sh_lz_q  <= 1'b0;
      an_q     <= '1;
      seg_q    <= '1;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else if (!en) begin
      an_q  <= '1;
      seg_q <= '1;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      idx_q <= idx_d;
      if (snap) begin
        sh_bcd_q <= bcd_in;
        sh_dp_q  <= dp_in;
        sh_lz_q  <= blank_lz;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
